nn_inference_ctrl: RTL and testbench
====================================

NN_INFERENCE_CTRL -- requirements
Module: nn_inference_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, the number of output classes.
REQ-002 SHALL have parameter PROB_W, default 16, the unsigned probability width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, the maximum number of cycles to wait for NN_Done.
REQ-004 SHALL have port Clk, input, 1, the single system clock; all logic is rising-edge.
REQ-005 SHALL have port Reset_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port Start, input, 1, a one-cycle request (already synchronised) to run one inference.
REQ-007 SHALL have port NN_Compute, output, 1, a one-cycle launch pulse to the neural network.
REQ-008 SHALL have port NN_Done, input, 1, asserted by the network when Probability is stable (level or pulse).
REQ-009 SHALL have port Probability, input, NUM_CLASSES*PROB_W, the flattened class scores; class k occupies bits [k*PROB_W +: PROB_W].
REQ-010 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port Class, output, 4, the argmax class index of the last successful run.
REQ-012 SHALL have port Class_Prob, output, PROB_W, the score of Class.
REQ-013 SHALL have port Valid, output, 1, a one-cycle pulse on which Class and Class_Prob update.
REQ-014 SHALL have port Timeout_Err, output, 1, a sticky error flag for the last run.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, WAIT, SCAN and DONE.
REQ-016 In IDLE, Start=1 SHALL move the FSM to LAUNCH on the next edge and clear Timeout_Err at that edge.
REQ-017 LAUNCH SHALL assert NN_Compute for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-018 In WAIT, NN_Done=1 SHALL move the FSM to SCAN; NN_Done SHALL be ignored in every other state.
REQ-019 In WAIT, the counter SHALL increment each cycle; reaching TIMEOUT_CYC without NN_Done SHALL set Timeout_Err, return to IDLE, leave Class and Class_Prob unchanged, and produce no Valid pulse.
REQ-020 In SCAN, the block SHALL evaluate one class per cycle for index 0..NUM_CLASSES-1, holding a running best index and best score.
REQ-021 Index 0 SHALL load the best index and score unconditionally; each later index SHALL replace them only if its score is strictly greater (unsigned), so the lowest index wins a tie.
REQ-022 After index NUM_CLASSES-1, the FSM SHALL go to DONE; in DONE, Class and Class_Prob SHALL load the best values, Valid SHALL be 1 for that one cycle, and the FSM SHALL then return to IDLE.
REQ-023 Latency SHALL be fixed: with Start at cycle 0 and NN_Done first seen in WAIT at cycle d, Valid SHALL be high at cycle d+NUM_CLASSES+1.
REQ-024 Start SHALL be ignored whenever Busy=1; there SHALL be no queueing.
REQ-025 A Start in the same cycle as Valid (state DONE) SHALL be ignored.
REQ-026 NN_Compute SHALL never be asserted outside LAUNCH.
REQ-027 Class and Class_Prob SHALL hold their values between Valid pulses.
REQ-028 Probability SHALL be sampled only during SCAN; the network holds it stable from NN_Done until Valid.

Reset
REQ-029 Reset_n=0 SHALL immediately force the state to IDLE and set NN_Compute, Busy, Valid and Timeout_Err to 0, Class to 0, Class_Prob to 0, and the internal counter and running best to 0.
REQ-030 Reset asserted mid-run (any state) SHALL abort the run with no Valid pulse; the first Start after release SHALL behave as from power-up.
REQ-031 Reset release SHALL take effect synchronously to Clk; no output SHALL glitch high at release.

Verification
REQ-032 Scores {5,9,3,100,2,7,0,1,99,4}, Start, NN_Done 3 cycles after NN_Compute -> one NN_Compute pulse, then Valid with Class=3, Class_Prob=100 at the cycle given by REQ-023.
REQ-033 Tie: class 2 and class 7 both 0xFFFF, all others 0 -> Class=2, Class_Prob=0xFFFF.
REQ-034 All scores 0 -> Class=0, Class_Prob=0, Valid pulses once.
REQ-035 TIMEOUT_CYC=20, NN_Done never asserted -> Timeout_Err=1 after 20 WAIT cycles, Busy falls, no Valid, Class keeps its prior value; the next Start clears Timeout_Err.
REQ-036 Start re-pulsed during WAIT and during SCAN -> exactly one NN_Compute and one Valid for the run.
REQ-037 Reset_n pulsed low during SCAN -> outputs go to their reset values immediately, no Valid; the following Start and NN_Done with the REQ-032 vector -> Class=3.

Source files
------------

// File: rtl/nn_inference_ctrl.sv
// Inference sequencer: launches the network, waits for completion (with a
// timeout), then scans the class scores one per cycle and reports argmax.
module nn_inference_ctrl #(
    parameter int NUM_CLASSES = 10,
    parameter int PROB_W      = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Start,
    output logic                          NN_Compute,
    input  logic                          NN_Done,
    input  logic [NUM_CLASSES*PROB_W-1:0] Probability,
    output logic                          Busy,
    output logic [3:0]                    Class,
    output logic [PROB_W-1:0]             Class_Prob,
    output logic                          Valid,
    output logic                          Timeout_Err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_CLASSES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SCAN   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [3:0]        scan_idx;
    logic [3:0]        best_idx;
    logic [PROB_W-1:0] best_prob;
    logic [PROB_W-1:0] cur_prob;
    logic              take_cur;
    logic [3:0]        nxt_idx;
    logic [PROB_W-1:0] nxt_prob;

    // Strobes decode straight from the state register, so they cannot glitch
    // and drop with the asynchronous reset.
    assign NN_Compute = (state == S_LAUNCH);
    assign Busy       = (state != S_IDLE);
    assign Valid      = (state == S_DONE);

    // Score under evaluation; index 0 always seeds, later ones must beat
    // strictly so the lowest index wins a tie.
    assign cur_prob = Probability[int'(scan_idx)*PROB_W +: PROB_W];
    assign take_cur = (scan_idx == 4'd0) || (cur_prob > best_prob);
    assign nxt_idx  = take_cur ? scan_idx : best_idx;
    assign nxt_prob = take_cur ? cur_prob : best_prob;

    // Control FSM, wait counter, running best and result registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_prob   <= '0;
            Class       <= '0;
            Class_Prob  <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state       <= S_LAUNCH;
                        Timeout_Err <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (NN_Done) begin
                        scan_idx <= '0;
                        state    <= S_SCAN;
                    end else if (wait_cnt == CNT_LAST) begin
                        Timeout_Err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_SCAN: begin
                    best_idx  <= nxt_idx;
                    best_prob <= nxt_prob;
                    if (scan_idx == IDX_LAST) begin
                        // Result registers load on entry to DONE so they are
                        // already presented during the Valid cycle.
                        Class      <= nxt_idx;
                        Class_Prob <= nxt_prob;
                        state      <= S_DONE;
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Scoreboard bench for nn_inference_ctrl: each run pushes its expected
// class/score/cycle when NN_Done is driven; the Valid monitor pops and checks.
module tb_nn_inference_ctrl;

    localparam int NC = 10;
    localparam int PW = 16;
    localparam int TO = 20;

    typedef int score_t [NC];
    typedef struct {
        int cls;
        int prob;
        int at;
    } exp_t;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic             NN_Compute;
    logic             NN_Done;
    logic [NC*PW-1:0] Probability;
    logic             Busy;
    logic [3:0]       Class;
    logic [PW-1:0]    Class_Prob;
    logic             Valid;
    logic             Timeout_Err;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_compute = 0;
    exp_t sb[$];
    exp_t mon_e;

    nn_inference_ctrl #(.NUM_CLASSES(NC), .PROB_W(PW), .TIMEOUT_CYC(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .NN_Compute(NN_Compute),
        .NN_Done(NN_Done), .Probability(Probability), .Busy(Busy), .Class(Class),
        .Class_Prob(Class_Prob), .Valid(Valid), .Timeout_Err(Timeout_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NC*PW-1:0] pack(input score_t s);
        logic [NC*PW-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) r[k*PW +: PW] = PW'(s[k]);
        return r;
    endfunction

    // Output monitor: counts launches and checks every Valid against the queue.
    always @(negedge Clk) begin
        if (NN_Compute) n_compute++;
        if (Valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("class", 32'(Class), 32'(mon_e.cls));
                chk("class_prob", 32'(Class_Prob), 32'(mon_e.prob));
                chk("valid_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    // Start a run and wait until the launch strobe is visible.
    task automatic launch(input score_t s);
        int k;
        Probability = pack(s);
        Start = 1'b1;
        step();
        Start = 1'b0;
        k = 0;
        while (!NN_Compute && k < 20) begin
            step();
            k++;
        end
        chk("launch_seen", 32'(NN_Compute), 32'd1);
        chk("terr_clear", 32'(Timeout_Err), 32'd0);
    endtask

    // One full inference; optional Start re-pulses during WAIT and SCAN.
    task automatic run(input score_t s, input int dly, input int ecls,
                       input int eprob, input bit repulse);
        int c0;
        int k;
        c0 = n_compute;
        launch(s);
        for (int i = 0; i < dly; i++) begin
            step();
            Start = repulse && (i == 0);
        end
        Start = 1'b0;
        NN_Done = 1'b1;
        sb.push_back('{ecls, eprob, cyc + NC + 1});
        step();
        NN_Done = 1'b0;
        if (repulse) begin
            Start = 1'b1;
            step();
            Start = 1'b0;
        end
        k = 0;
        while (!Valid && k < 40) begin
            step();
            k++;
        end
        chk("valid_seen", 32'(Valid), 32'd1);
        // A Start coinciding with Valid must be dropped.
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("busy_after_done", 32'(Busy), 32'd0);
        chk("valid_one_cycle", 32'(Valid), 32'd0);
        repeat (4) step();
        chk("one_launch", 32'(n_compute - c0), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("class_hold", 32'(Class), 32'(ecls));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        Reset_n = 1'b0;
        Start = 1'b0;
        NN_Done = 1'b0;
        Probability = '0;
        repeat (3) step();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_compute", 32'(NN_Compute), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_terr", 32'(Timeout_Err), 32'd0);
        chk("rst_class", 32'(Class), 32'd0);
        chk("rst_prob", 32'(Class_Prob), 32'd0);
        Reset_n = 1'b1;
        step();
        chk("release_busy", 32'(Busy), 32'd0);

        // Basic argmax, NN_Done 3 cycles after launch.
        run('{5, 9, 3, 100, 2, 7, 0, 1, 99, 4}, 3, 3, 100, 1'b0);

        // Timeout: NN_Done never arrives; result registers hold.
        launch('{1, 1, 1, 1, 1, 1, 1, 1, 1, 1});
        k = 0;
        while (!Timeout_Err && k < 40) begin
            step();
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'(TO + 1));
        chk("timeout_flag", 32'(Timeout_Err), 32'd1);
        chk("timeout_busy", 32'(Busy), 32'd0);
        chk("timeout_class", 32'(Class), 32'd3);
        chk("timeout_prob", 32'(Class_Prob), 32'd100);
        repeat (3) step();
        chk("timeout_sticky", 32'(Timeout_Err), 32'd1);

        // Tie: lowest index wins.
        run('{0, 0, 65535, 0, 0, 0, 0, 65535, 0, 0}, 2, 2, 65535, 1'b0);
        // All zero, NN_Done on the first WAIT cycle.
        run('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 0, 1'b0);
        // Maximum in the last slot, Start re-pulsed in WAIT and SCAN.
        run('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 4, 9, 10, 1'b1);

        // Reset in the middle of SCAN aborts the run.
        launch('{5, 9, 3, 100, 2, 7, 0, 1, 99, 4});
        repeat (3) step();
        NN_Done = 1'b1;
        step();
        NN_Done = 1'b0;
        repeat (3) step();
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_valid", 32'(Valid), 32'd0);
        chk("mid_rst_compute", 32'(NN_Compute), 32'd0);
        chk("mid_rst_class", 32'(Class), 32'd0);
        chk("mid_rst_prob", 32'(Class_Prob), 32'd0);
        step();
        Reset_n = 1'b1;
        repeat (15) step();
        chk("mid_rst_idle", 32'(Busy), 32'd0);
        run('{5, 9, 3, 100, 2, 7, 0, 1, 99, 4}, 3, 3, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
